// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: MD op codes,
// default latencies and the controller state type.
package e_mdu_pkg;

    localparam logic [3:0] MD_none  = 4'd0;
    localparam logic [3:0] MD_mult  = 4'd1;
    localparam logic [3:0] MD_multu = 4'd2;
    localparam logic [3:0] MD_div   = 4'd3;
    localparam logic [3:0] MD_divu  = 4'd4;
    localparam logic [3:0] MD_mthi  = 4'd5;
    localparam logic [3:0] MD_mtlo  = 4'd6;
    localparam logic [3:0] MD_mfhi  = 4'd7;
    localparam logic [3:0] MD_mflo  = 4'd8;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_md_launch(input logic [3:0] op);
        return (op == MD_mult) || (op == MD_multu) || (op == MD_div) || (op == MD_divu);
    endfunction

endpackage

// File: rtl/e_mdu_md_calc.sv
// Combinational multiply/divide datapath producing {hi, lo}.
// Divide-by-zero returns the current HI/LO so the commit leaves them unchanged.
module e_mdu_md_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        is_sdiv;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] safe_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign is_sdiv = (op == MD_div);
    assign abs_a   = (is_sdiv && a[31]) ? -a : a;
    assign abs_b   = (is_sdiv && b[31]) ? -b : b;
    assign safe_b  = (b == 32'd0) ? 32'd1 : abs_b;
    assign uq      = abs_a / safe_b;
    assign ur      = abs_a % safe_b;
    assign q       = (is_sdiv && (a[31] ^ b[31])) ? -uq : uq;
    assign r       = (is_sdiv && a[31]) ? -ur : ur;

    always_comb begin
        result = 64'd0;
        case (op)
            MD_mult:  result = prod_s;
            MD_multu: result = prod_u;
            MD_div,
            MD_divu:  result = (b == 32'd0) ? {cur_hi, cur_lo} : {r, q};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div over a fixed
// latency and requests a pipeline stall while an operation is in flight.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [3:0]  i_mdOp,
    input  logic [31:0] i_srcA,
    input  logic [31:0] i_srcB,
    output logic        o_busy,
    output logic        o_stallReq,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic [31:0] o_result
);

    localparam int CNT_W = 8;

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      shadow_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [63:0]      calc;
    logic             launch;

    e_mdu_md_calc u_md_calc (
        .op     (i_mdOp),
        .a      (i_srcA),
        .b      (i_srcB),
        .cur_hi (hi_q),
        .cur_lo (lo_q),
        .result (calc)
    );

    assign launch = i_start & is_md_launch(i_mdOp);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        shadow_q <= calc;
                        cnt_q    <= ((i_mdOp == MD_mult) || (i_mdOp == MD_multu))
                                    ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    end else if (i_mdOp == MD_mthi) begin
                        hi_q <= i_srcA;
                    end else if (i_mdOp == MD_mtlo) begin
                        lo_q <= i_srcA;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q <= shadow_q[63:32];
                        lo_q <= shadow_q[31:0];
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign o_busy     = (state_q == S_BUSY);
    assign o_stallReq = o_busy | launch;
    assign o_hi       = hi_q;
    assign o_lo       = lo_q;
    assign o_result   = (i_mdOp == MD_mfhi) ? hi_q :
                        (i_mdOp == MD_mflo) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops and compares whenever an operation completes.
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [3:0]  i_mdOp = MD_none;
    logic [31:0] i_srcA = '0;
    logic [31:0] i_srcB = '0;
    logic        o_busy;
    logic        o_stallReq;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic [31:0] o_result;

    e_mdu dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_mdOp     (i_mdOp),
        .i_srcA     (i_srcA),
        .i_srcB     (i_srcB),
        .o_busy     (o_busy),
        .o_stallReq (o_stallReq),
        .o_hi       (o_hi),
        .o_lo       (o_lo),
        .o_result   (o_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        prev_busy = 1'b0;
    int          busy_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic rules, using 64-bit integer math.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_mult:  return 64'(sa * sb);
            MD_multu: return ua * ub;
            MD_div: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MD_divu: begin
                if (b == 32'd0) return {hi, lo};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return 64'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (o_busy) begin
            busy_len++;
        end else if (prev_busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_hi", o_hi, e.hi);
                check("commit_lo", o_lo, e.lo);
                if (e.len >= 0) check("busy_cycles", 32'(busy_len), 32'(e.len));
            end
            busy_len = 0;
        end
        prev_busy = o_busy;
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40; i++) begin
            if (!o_busy) break;
            @(negedge clk);
        end
        if (i == 40) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        exp_t        e;
        @(negedge clk);
        i_mdOp = op;
        i_srcA = a;
        i_srcB = b;
        i_start = is_md_launch(op);
        if (is_md_launch(op)) begin
            r = model(op, a, b, m_hi, m_lo);
            e.hi = r[63:32];
            e.lo = r[31:0];
            e.len = ((op == MD_mult) || (op == MD_multu)) ? MD_MULT_CYCLES : MD_DIV_CYCLES;
            exp_q.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
            #1 check("stall_on_launch", 32'(o_stallReq), 32'd1);
        end else if (op == MD_mthi) begin
            m_hi = a;
        end else if (op == MD_mtlo) begin
            m_lo = a;
        end
        @(negedge clk);
        i_start = 1'b0;
        i_mdOp = MD_none;
        if (is_md_launch(op)) wait_idle();
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        i_reset = 1'b1;
        i_start = 1'b0;
        i_mdOp = MD_none;
        exp_q.delete();
        if (o_busy) begin
            e.hi = '0;
            e.lo = '0;
            e.len = -1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        i_reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic check_mf();
        @(negedge clk);
        i_mdOp = MD_mfhi;
        #1 check("mfhi_result", o_result, m_hi);
        i_mdOp = MD_mflo;
        #1 check("mflo_result", o_result, m_lo);
        i_mdOp = MD_none;
        #1 check("result_none", o_result, 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_hi", o_hi, 32'd0);
        check("reset_lo", o_lo, 32'd0);

        issue(MD_mult, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi", o_hi, 32'hFFFF_FFFF);
        check("mult_lo", o_lo, 32'hFFFF_FFFA);
        issue(MD_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_hi", o_hi, 32'hFFFF_FFFE);
        check("multu_lo", o_lo, 32'h0000_0001);
        issue(MD_div, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", o_lo, 32'hFFFF_FFFD);
        check("div_hi", o_hi, 32'hFFFF_FFFF);
        issue(MD_div, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf_lo", o_lo, 32'h8000_0000);
        check("divovf_hi", o_hi, 32'd0);
        issue(MD_mthi, 32'h1234, 32'd0);
        issue(MD_mtlo, 32'h5678, 32'd0);
        check("mthi", o_hi, 32'h1234);
        check("mtlo", o_lo, 32'h5678);
        issue(MD_divu, 32'd7, 32'd0);
        check("divu0_hi", o_hi, 32'h1234);
        check("divu0_lo", o_lo, 32'h5678);
        check_mf();

        // start with a non-launch op is ignored
        @(negedge clk);
        i_start = 1'b1;
        i_mdOp = MD_mfhi;
        #1 check("nonmd_stall", 32'(o_stallReq), 32'd0);
        @(negedge clk);
        i_start = 1'b0;
        i_mdOp = MD_none;
        check("nonmd_busy", 32'(o_busy), 32'd0);

        // reset in the middle of a mult
        issue(MD_mtlo, 32'd9, 32'd0);
        @(negedge clk);
        i_mdOp = MD_mult;
        i_srcA = 32'd2;
        i_srcB = 32'd2;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_mdOp = MD_none;
        @(negedge clk);
        do_reset();
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_hi", o_hi, 32'd0);
        check("rst_mid_lo", o_lo, 32'd0);
        repeat (6) @(negedge clk);
        check("no_late_hi", o_hi, 32'd0);
        check("no_late_lo", o_lo, 32'd0);

        // reset and start together
        @(negedge clk);
        i_reset = 1'b1;
        i_start = 1'b1;
        i_mdOp = MD_mult;
        @(negedge clk);
        i_reset = 1'b0;
        i_start = 1'b0;
        i_mdOp = MD_none;
        check("rst_start_busy", 32'(o_busy), 32'd0);

        // second start and mtlo while busy are both ignored
        begin
            exp_t e;
            @(negedge clk);
            i_mdOp = MD_mult;
            i_srcA = 32'h10;
            i_srcB = 32'h20;
            i_start = 1'b1;
            e.hi = 32'd0;
            e.lo = 32'h200;
            e.len = MD_MULT_CYCLES;
            exp_q.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
            @(negedge clk);
            i_start = 1'b0;
            i_mdOp = MD_none;
            @(negedge clk);
            i_mdOp = MD_div;
            i_srcA = 32'd100;
            i_srcB = 32'd3;
            i_start = 1'b1;
            #1 check("stall_while_busy", 32'(o_stallReq), 32'd1);
            @(negedge clk);
            i_start = 1'b0;
            i_mdOp = MD_mtlo;
            i_srcA = 32'h99;
            @(negedge clk);
            i_mdOp = MD_none;
            wait_idle();
            check_mf();
            repeat (3) @(negedge clk);
            check("no_second_op", 32'(o_busy), 32'd0);
        end

        for (int k = 0; k < 40; k++) begin
            logic [3:0] op;
            op = 4'($urandom_range(1, 6));
            issue(op, rand_operand(), rand_operand());
            if (k % 4 == 3) check_mf();
        end
        check_mf();

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Sequential counterpart to the combinational E-stage ALU: it owns the HI/LO registers and runs mult/multu/div/divu over a fixed multi-cycle latency.
- Raises a busy/stall request toward the hazard unit.
- Serves mthi/mtlo writes and mfhi/mflo reads.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  launch request; only effective with a mult/div op.
- i_mdOp  input  4  MD operation code (MD_* constants).
- i_srcA  input  32  rs operand (forwarded).
- i_srcB  input  32  rt operand (forwarded).
- o_busy  output  1  operation in flight.
- o_stallReq  output  1  o_busy | (i_start & op is mult/multu/div/divu).
- o_hi  output  32  current HI register.
- o_lo  output  32  current LO register.
- o_result  output  32  HI if i_mdOp==MD_mfhi, LO if MD_mflo, else 0.

Behaviour:
- Reset: at an edge with i_reset=1:
  - HI=0, LO=0, state=IDLE, counter=0, o_busy=0.
  - Any in-flight result is discarded; HI/LO are not updated.
- FSM states: IDLE, BUSY.
- IDLE → BUSY:
  - Taken at an edge where i_start=1 and i_mdOp ∈ {mult, multu, div, divu}.
  - Latch the result into shadow regs: hiNext/loNext, 64-bit product or {remainder, quotient}.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- BUSY: counter decrements each edge. At the edge where counter==1:
  - HI←hiNext, LO←loNext.
  - State → IDLE.
- Timing:
  - Start sampled at edge t0.
  - o_busy=1 during cycles t0+1 … t0+N.
  - New HI/LO visible, with o_busy=0, from cycle t0+N+1.
- Start while BUSY: ignored. The pipeline stalls, so this only happens on a protocol violation; the in-flight op is unaffected.
- i_start with a non-mult/div op: ignored.
- mthi/mtlo:
  - Take effect in IDLE at the next edge: HI←i_srcA or LO←i_srcA.
  - No busy cycles.
  - Ignored while BUSY.
- mfhi/mflo: o_result is combinational from the current HI/LO. There is no bypass of a pending shadow result.
- Arithmetic rules:
  - mult: signed 32x32→64; HI=upper word, LO=lower word.
  - multu: unsigned 32x32→64; same split.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div or divu with i_srcB==0): full busy latency still elapses; HI and LO are left unchanged.
- Reset mid-operation: next cycle o_busy=0, HI=LO=0; counter cleared.
- Simultaneous i_reset and i_start: reset wins.

Decomposition:
- Shared def.v package gains:
  - MD_none=0, MD_mult=1, MD_multu=2, MD_div=3, MD_divu=4, MD_mthi=5, MD_mtlo=6, MD_mfhi=7, MD_mflo=8 (4-bit).
  - MD_MULT_CYCLES / MD_DIV_CYCLES defaults.
- One natural sub-module: md_calc. It is combinational and takes op, A and B; it outputs the 64-bit {hi, lo} including the div-by-zero and overflow rules.
- e_mdu holds the FSM, counter, shadow registers and HI/LO.

Test Plan:
- mult, A=0xFFFFFFFE (-2), B=3, start at t0 → o_busy high for cycles t0+1..t0+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- div, A=-7 (0xFFFFFFF9), B=2 → 10 busy cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, A=7, B=0, after mthi 0x1234 and mtlo 0x5678 → 10 busy cycles; then HI=0x1234, LO=0x5678 unchanged.
- Reset at cycle t0+3 of a mult with A=B=2, preceded by mtlo 9 → cycle after reset: o_busy=0, HI=LO=0; no late update at t0+6.
- Second start during BUSY plus an mtlo during BUSY → both ignored; first op's HI/LO land on schedule; mflo then returns the first op's LO on o_result.
